// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU sequencer: opcodes, FSM states, instruction fields.
// Pure declarations, no logic and no latency.
// Imported by the sequencer and its skew generator.
package tpu_pkg;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int IMM_W   = 13;

  typedef enum logic [2:0] {
    OP_NOP         = 3'b000,
    OP_LOAD_ADDR   = 3'b001,
    OP_LOAD_WEIGHT = 3'b010,
    OP_SET_OUT     = 3'b011,
    OP_COMPUTE     = 3'b100
  } opc_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_FEED   = 2'd2
  } state_t;

endpackage

// File: rtl/tpu_skew_gen.sv
// Per-lane UB read and per-column UB write strobes/addresses for the skewed FEED phase.
// Purely combinational from cnt; lane r reads row k at cnt=k+r, column c writes row k at cnt=k+c+N+1.
// No backpressure; the caller gates the outputs to the FEED state.
module tpu_skew_gen
  import tpu_pkg::*;
#(
  parameter int N      = 2,
  parameter int ADDR_W = 6,
  parameter int CNT_W  = 3
) (
  input  logic [CNT_W-1:0]    cnt,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W-1:0]   out_addr,
  output logic [N-1:0]        rd_en,
  output logic [N*ADDR_W-1:0] rd_addr,
  output logic [N-1:0]        wr_en,
  output logic [N*ADDR_W-1:0] wr_addr
);

  int k;

  // Decode the skewed schedule: each lane/column finds which row k it handles this cycle.
  always_comb begin
    rd_en   = '0;
    rd_addr = '0;
    wr_en   = '0;
    wr_addr = '0;
    k       = 0;
    for (int r = 0; r < N; r++) begin
      k = int'(cnt) - r;
      if (k >= 0 && k < N) begin
        rd_en[r] = 1'b1;
        rd_addr[r*ADDR_W +: ADDR_W] = base_addr + ADDR_W'(k * N + r);
      end
      k = int'(cnt) - r - N - 1;
      if (k >= 0 && k < N) begin
        wr_en[r] = 1'b1;
        wr_addr[r*ADDR_W +: ADDR_W] = out_addr + ADDR_W'(k * N + r);
      end
    end
  end

endmodule

// File: rtl/tpu_sequencer.sv
// Instruction decoder and sequencer for the NxN weight-stationary array and unified buffer.
// LOAD_W takes N*N+1 cycles, FEED takes 3N+1 cycles; register ops complete in one cycle.
// instr_ready is high only in IDLE; a source must hold its instruction until accepted.
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int N        = 2,
  parameter int ADDR_W   = 6,
  parameter int WT_IDX_W = $clog2(N*N)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [15:0]         instruction,
  input  logic                instr_valid,
  output logic                instr_ready,
  output logic [N-1:0]        ub_rd_en,
  output logic [N*ADDR_W-1:0] ub_rd_addr,
  output logic [N-1:0]        lane_valid,
  output logic                wt_we,
  output logic [WT_IDX_W-1:0] wt_idx,
  output logic [N-1:0]        ub_wr_en,
  output logic [N*ADDR_W-1:0] ub_wr_addr,
  output logic                busy,
  output logic                done,
  output logic                illegal_op
);

  localparam int CNT_MAX = (N*N > 3*N) ? N*N : 3*N;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic [ADDR_W-1:0]   base_addr, out_addr;
  logic [2:0]          opcode;
  logic                accept;
  logic                illegal_nxt;
  logic [N-1:0]        feed_rd_en, feed_wr_en;
  logic [N*ADDR_W-1:0] feed_rd_addr, feed_wr_addr;
  logic                unused_imm;

  assign opcode     = instruction[OPC_MSB:OPC_LSB];
  assign accept     = instr_valid && (state == ST_IDLE);
  assign unused_imm = ^instruction[IMM_W-1:ADDR_W];

  tpu_skew_gen #(.N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_skew (
    .cnt       (cnt),
    .base_addr (base_addr),
    .out_addr  (out_addr),
    .rd_en     (feed_rd_en),
    .rd_addr   (feed_rd_addr),
    .wr_en     (feed_wr_en),
    .wr_addr   (feed_wr_addr)
  );

  // State and phase counter; cnt restarts at 0 on every state entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode and all strobes, derived from the registered state so reset clears them at once.
  always_comb begin
    state_nxt   = state;
    instr_ready = (state == ST_IDLE);
    busy        = (state != ST_IDLE);
    done        = 1'b0;
    wt_we       = 1'b0;
    wt_idx      = '0;
    ub_rd_en    = '0;
    ub_rd_addr  = '0;
    ub_wr_en    = '0;
    ub_wr_addr  = '0;
    illegal_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          case (opcode)
            OP_LOAD_WEIGHT: state_nxt = ST_LOAD_W;
            OP_COMPUTE:     state_nxt = ST_FEED;
            OP_NOP, OP_LOAD_ADDR, OP_SET_OUT: ;
            default:        illegal_nxt = 1'b1;
          endcase
        end
      end
      ST_LOAD_W: begin
        if (cnt < CNT_W'(N*N)) begin
          ub_rd_en[0]             = 1'b1;
          ub_rd_addr[ADDR_W-1:0] = base_addr + ADDR_W'(cnt);
        end
        // Weight data lands one cycle after its read, so the index trails cnt by one.
        if (cnt != '0) begin
          wt_we  = 1'b1;
          wt_idx = WT_IDX_W'(cnt - CNT_W'(1));
        end
        if (cnt == CNT_W'(N*N)) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_FEED: begin
        ub_rd_en   = feed_rd_en;
        ub_rd_addr = feed_rd_addr;
        ub_wr_en   = feed_wr_en;
        ub_wr_addr = feed_wr_addr;
        if (cnt == CNT_W'(3*N)) begin
          done      = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    cnt_nxt = (state_nxt != state || state == ST_IDLE) ? '0 : cnt + CNT_W'(1);
  end

  // Address registers written by LOAD_ADDR / SET_OUT; only the low ADDR_W immediate bits matter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_addr <= '0;
      out_addr  <= '0;
    end else if (accept) begin
      if (opcode == OP_LOAD_ADDR) base_addr <= instruction[ADDR_W-1:0];
      if (opcode == OP_SET_OUT)   out_addr  <= instruction[ADDR_W-1:0];
    end
  end

  // UB read data arrives a cycle after the strobe; illegal_op is reported the cycle after acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_valid <= '0;
      illegal_op <= 1'b0;
    end else begin
      lane_valid <= ub_rd_en;
      illegal_op <= illegal_nxt;
    end
  end

endmodule

// File: tb/tb_tpu_sequencer.sv
// Directed, table-driven bench for tpu_sequencer with N=2, ADDR_W=6.
// Each table row drives one cycle of inputs and states the outputs expected in that cycle.
// Hand sequences cover held instructions while busy and reset in the middle of FEED.
module tb_tpu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [1:0]  ub_rd_en;
  logic [11:0] ub_rd_addr;
  logic [1:0]  lane_valid;
  logic        wt_we;
  logic [1:0]  wt_idx;
  logic [1:0]  ub_wr_en;
  logic [11:0] ub_wr_addr;
  logic        busy;
  logic        done;
  logic        illegal_op;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  tpu_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .ub_rd_en    (ub_rd_en),
    .ub_rd_addr  (ub_rd_addr),
    .lane_valid  (lane_valid),
    .wt_we       (wt_we),
    .wt_idx      (wt_idx),
    .ub_wr_en    (ub_wr_en),
    .ub_wr_addr  (ub_wr_addr),
    .busy        (busy),
    .done        (done),
    .illegal_op  (illegal_op)
  );

  // fl = {instr_ready, busy, done, illegal_op, wt_we}; addresses only matter where strobed.
  typedef struct {
    string       name;
    logic [15:0] ins;
    logic        vld;
    logic [4:0]  fl;
    logic [1:0]  widx;
    logic [1:0]  rden;
    logic [1:0]  lv;
    logic [1:0]  wren;
    logic [5:0]  ra0, ra1, wa0, wa1;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(string n, logic [15:0] ins, logic vld, logic [4:0] fl,
                             logic [1:0] widx, logic [1:0] rden, logic [1:0] lv,
                             logic [1:0] wren, int ra0, int ra1, int wa0, int wa1);
    vec_t r;
    r.name = n; r.ins = ins; r.vld = vld; r.fl = fl; r.widx = widx;
    r.rden = rden; r.lv = lv; r.wren = wren;
    r.ra0 = 6'(ra0); r.ra1 = 6'(ra1); r.wa0 = 6'(wa0); r.wa1 = 6'(wa1);
    return r;
  endfunction

  function automatic vec_t idle(string n, logic [15:0] ins, logic vld);
    return v(n, ins, vld, 5'b10000, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  logic [36:0] act_v, exp_v;
  int          busy_cycles;
  logic        seen_idle;

  initial begin
    // Load-weight from base 15, then compute with base 4 / out 0x20, then wrap and illegal opcode.
    tbl.push_back(idle("ld_addr_0f", 16'h200F, 1'b1));
    tbl.push_back(idle("ld_weight",  16'h4000, 1'b1));
    tbl.push_back(v("lw_cnt0", 16'h0, 1'b0, 5'b01000, 2'd0, 2'b01, 2'b00, 2'b00, 15, 0, 0, 0));
    tbl.push_back(v("lw_cnt1", 16'h0, 1'b0, 5'b01001, 2'd0, 2'b01, 2'b01, 2'b00, 16, 0, 0, 0));
    tbl.push_back(v("lw_cnt2", 16'h0, 1'b0, 5'b01001, 2'd1, 2'b01, 2'b01, 2'b00, 17, 0, 0, 0));
    tbl.push_back(v("lw_cnt3", 16'h0, 1'b0, 5'b01001, 2'd2, 2'b01, 2'b01, 2'b00, 18, 0, 0, 0));
    tbl.push_back(v("lw_cnt4", 16'h0, 1'b0, 5'b01101, 2'd3, 2'b00, 2'b01, 2'b00,  0, 0, 0, 0));
    tbl.push_back(idle("set_out_20", 16'h6020, 1'b1));
    tbl.push_back(idle("ld_addr_04", 16'h2004, 1'b1));
    tbl.push_back(idle("compute",    16'h8000, 1'b1));
    tbl.push_back(v("feed_cnt0", 16'h0, 1'b0, 5'b01000, 2'd0, 2'b01, 2'b00, 2'b00, 4, 0,  0,  0));
    tbl.push_back(v("feed_cnt1", 16'h0, 1'b0, 5'b01000, 2'd0, 2'b11, 2'b01, 2'b00, 6, 5,  0,  0));
    tbl.push_back(v("feed_cnt2", 16'h0, 1'b0, 5'b01000, 2'd0, 2'b10, 2'b11, 2'b00, 0, 7,  0,  0));
    tbl.push_back(v("feed_cnt3", 16'h0, 1'b0, 5'b01000, 2'd0, 2'b00, 2'b10, 2'b01, 0, 0, 32,  0));
    tbl.push_back(v("feed_cnt4", 16'h0, 1'b0, 5'b01000, 2'd0, 2'b00, 2'b00, 2'b11, 0, 0, 34, 33));
    tbl.push_back(v("feed_cnt5", 16'h0, 1'b0, 5'b01000, 2'd0, 2'b00, 2'b00, 2'b10, 0, 0,  0, 35));
    tbl.push_back(v("feed_cnt6", 16'h0, 1'b0, 5'b01100, 2'd0, 2'b00, 2'b00, 2'b00, 0, 0,  0,  0));
    tbl.push_back(idle("ld_addr_3f", 16'h203F, 1'b1));
    tbl.push_back(idle("ld_weight2", 16'h4000, 1'b1));
    tbl.push_back(v("wrap_cnt0", 16'h0, 1'b0, 5'b01000, 2'd0, 2'b01, 2'b00, 2'b00, 63, 0, 0, 0));
    tbl.push_back(v("wrap_cnt1", 16'h0, 1'b0, 5'b01001, 2'd0, 2'b01, 2'b01, 2'b00,  0, 0, 0, 0));
    tbl.push_back(v("wrap_cnt2", 16'h0, 1'b0, 5'b01001, 2'd1, 2'b01, 2'b01, 2'b00,  1, 0, 0, 0));
    tbl.push_back(v("wrap_cnt3", 16'h0, 1'b0, 5'b01001, 2'd2, 2'b01, 2'b01, 2'b00,  2, 0, 0, 0));
    tbl.push_back(v("wrap_cnt4", 16'h0, 1'b0, 5'b01101, 2'd3, 2'b00, 2'b01, 2'b00,  0, 0, 0, 0));
    tbl.push_back(idle("illegal_111", 16'hE000, 1'b1));
    tbl.push_back(v("illegal_pulse", 16'h0, 1'b0, 5'b10010, 2'd0, 2'b00, 2'b00, 2'b00, 0, 0, 0, 0));
    tbl.push_back(idle("illegal_clear", 16'h0, 1'b0));

    reset       = 1'b1;
    instruction = 16'h0;
    instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs",
        {instr_ready, busy, done, illegal_op, wt_we, ub_rd_en, lane_valid, ub_wr_en},
        11'b100_0000_0000);
    @(negedge clk);
    reset = 1'b0;

    // Table: drive at the falling edge, compare shortly after.
    foreach (tbl[i]) begin
      @(negedge clk);
      instruction = tbl[i].ins;
      instr_valid = tbl[i].vld;
      #1;
      act_v = {instr_ready, busy, done, illegal_op, wt_we,
               (wt_we ? wt_idx : 2'b00), ub_rd_en, lane_valid, ub_wr_en,
               (ub_rd_en[0] ? ub_rd_addr[5:0]  : 6'd0),
               (ub_rd_en[1] ? ub_rd_addr[11:6] : 6'd0),
               (ub_wr_en[0] ? ub_wr_addr[5:0]  : 6'd0),
               (ub_wr_en[1] ? ub_wr_addr[11:6] : 6'd0)};
      exp_v = {tbl[i].fl, tbl[i].widx, tbl[i].rden, tbl[i].lv, tbl[i].wren,
               tbl[i].ra0, tbl[i].ra1, tbl[i].wa0, tbl[i].wa1};
      chk(tbl[i].name, act_v, exp_v);
    end

    // COMPUTE, then hold LOAD_ADDR 0x10 while busy; it must wait 7 cycles and be taken in IDLE.
    @(negedge clk);
    instruction = 16'h8000;
    instr_valid = 1'b1;
    #1 chk("compute2_ready", instr_ready, 1);
    @(negedge clk);
    instruction = 16'h2010;
    busy_cycles = 0;
    seen_idle   = 1'b0;
    for (int i = 0; i < 20 && !seen_idle; i++) begin
      #1;
      if (instr_ready) begin
        seen_idle = 1'b1;
      end else begin
        if (i == 0) chk("base_kept_after_illegal", {ub_rd_en[0], ub_rd_addr[5:0]}, {1'b1, 6'd63});
        if (i == 3) chk("out_kept_after_illegal",  {ub_wr_en[0], ub_wr_addr[5:0]}, {1'b1, 6'd32});
        busy_cycles++;
        @(negedge clk);
      end
    end
    chk("held_reached_idle", seen_idle, 1);
    chk("busy_hold_cycles", busy_cycles, 7);
    @(negedge clk);
    instruction = 16'h4000;
    #1 chk("held_then_ready", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    #1 chk("held_base_applied", {ub_rd_en[0], ub_rd_addr[5:0]}, {1'b1, 6'd16});
    repeat (5) @(negedge clk);
    #1 chk("lw_back_idle", {instr_ready, busy}, 2'b10);

    // Reset asserted at FEED cnt=2 must clear strobes before any clock edge.
    @(negedge clk);
    instruction = 16'h8000;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("feed_cnt2_before_reset", {ub_rd_en, lane_valid}, 4'b1011);
    reset = 1'b1;
    #1;
    chk("reset_async_strobes",
        {ub_rd_en, ub_wr_en, lane_valid, wt_we, done, busy, illegal_op}, 10'b0);
    chk("reset_async_ready", instr_ready, 1);
    @(negedge clk);
    reset       = 1'b0;
    instruction = 16'h4000;
    instr_valid = 1'b1;
    #1 chk("ready_after_release", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    #1 chk("base_cleared_by_reset", {ub_rd_en[0], ub_rd_addr[5:0]}, {1'b1, 6'd0});
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
